pipe_reg_ex_wb_multi: RTL and testbench

//  Parametrised EX->WB pipeline register: LANES parallel write-back channels, DEPTH register stages.

---
 rtl/pipe_reg_ex_wb_multi.sv | 101 ++++++++++
 tb/tb_pipe_reg_ex_wb_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_ex_wb_multi.sv
// EX->WB pipeline register: LANES parallel write-back channels delayed by DEPTH stages,
// with flush/stall control, a youngest-write forwarding lookup and an occupancy count.
module pipe_reg_ex_wb_multi #(
   parameter int LANES  = 2,
   parameter int DATA_W = 16,
   parameter int ADRS_W = 4,
   parameter int DEPTH  = 1
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             stall,
   input  logic                             flush,
   input  logic [LANES-1:0]                 in_wr_en,
   input  logic [LANES*ADRS_W-1:0]          in_dst,
   input  logic [LANES*DATA_W-1:0]          in_data,
   output logic [LANES-1:0]                 out_wr_en,
   output logic [LANES*ADRS_W-1:0]          out_dst,
   output logic [LANES*DATA_W-1:0]          out_data,
   input  logic [ADRS_W-1:0]                fwd_src,
   output logic                             fwd_hit,
   output logic [DATA_W-1:0]                fwd_data,
   output logic [$clog2(LANES*DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(LANES*DEPTH+1);

   if (LANES < 1 || DEPTH < 1 || DEPTH > 4 || DATA_W < 1 || ADRS_W < 1) begin : g_param_check
      $fatal(1, "pipe_reg_ex_wb_multi: illegal parameter combination");
   end

   // Stage 0 is the youngest entry, stage DEPTH-1 drives the register-file write port.
   logic [DEPTH-1:0][LANES-1:0]        stg_wr_en;
   logic [DEPTH-1:0][LANES*ADRS_W-1:0] stg_dst;
   logic [DEPTH-1:0][LANES*DATA_W-1:0] stg_data;

   logic [LANES*ADRS_W-1:0] cap_dst;
   logic [LANES*DATA_W-1:0] cap_data;

   // Disabled lanes are captured as canonical bubbles so stale dst/data never travel down the pipe.
   always_comb begin
      cap_dst  = '0;
      cap_data = '0;
      for (int l = 0; l < LANES; l++) begin
         if (in_wr_en[l]) begin
            cap_dst[l*ADRS_W +: ADRS_W]  = in_dst[l*ADRS_W +: ADRS_W];
            cap_data[l*DATA_W +: DATA_W] = in_data[l*DATA_W +: DATA_W];
         end
      end
   end

   // Stage registers: reset and flush clear everything, stall holds, otherwise shift by one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stg_wr_en <= '0;
         stg_dst   <= '0;
         stg_data  <= '0;
      end else if (flush) begin
         stg_wr_en <= '0;
         stg_dst   <= '0;
         stg_data  <= '0;
      end else if (!stall) begin
         stg_wr_en[0] <= in_wr_en;
         stg_dst[0]   <= cap_dst;
         stg_data[0]  <= cap_data;
         for (int s = 1; s < DEPTH; s++) begin
            stg_wr_en[s] <= stg_wr_en[s-1];
            stg_dst[s]   <= stg_dst[s-1];
            stg_data[s]  <= stg_data[s-1];
         end
      end
   end

   assign out_wr_en = stg_wr_en[DEPTH-1];
   assign out_dst   = stg_dst[DEPTH-1];
   assign out_data  = stg_data[DEPTH-1];

   // Forwarding: scan oldest to youngest and low to high lane so the last match written is the youngest write.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int s = DEPTH-1; s >= 0; s--) begin
         for (int l = 0; l < LANES; l++) begin
            if (stg_wr_en[s][l] && (stg_dst[s][l*ADRS_W +: ADRS_W] == fwd_src)) begin
               fwd_hit  = 1'b1;
               fwd_data = stg_data[s][l*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Occupancy is the number of valid writes currently held across all stages.
   always_comb begin
      occupancy = '0;
      for (int s = 0; s < DEPTH; s++) begin
         for (int l = 0; l < LANES; l++) begin
            occupancy = occupancy + OCC_W'(stg_wr_en[s][l]);
         end
      end
   end

endmodule

// File: tb/tb_pipe_reg_ex_wb_multi.sv
// Testbench for pipe_reg_ex_wb_multi: a scoreboarded main instance (2 lanes, depth 2)
// plus small instances for stall (depth 1), flush-over-stall (depth 3) and full occupancy (4x4).
module tb_pipe_reg_ex_wb_multi;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   typedef struct {
      logic [1:0]  wr_en;
      logic [7:0]  dst;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_exp;

   // Main instance: LANES=2, DEPTH=2
   logic        a_stall = 1'b0, a_flush = 1'b0;
   logic [1:0]  a_in_wr_en = '0;
   logic [7:0]  a_in_dst = '0;
   logic [31:0] a_in_data = '0;
   logic [1:0]  a_out_wr_en;
   logic [7:0]  a_out_dst;
   logic [31:0] a_out_data;
   logic [3:0]  a_fwd_src = '0;
   logic        a_fwd_hit;
   logic [15:0] a_fwd_data;
   logic [2:0]  a_occ;

   // Stall instance: LANES=2, DEPTH=1
   logic        b_stall = 1'b0, b_flush = 1'b0;
   logic [1:0]  b_in_wr_en = '0;
   logic [7:0]  b_in_dst = '0;
   logic [31:0] b_in_data = '0;
   logic [1:0]  b_out_wr_en;
   logic [7:0]  b_out_dst;
   logic [31:0] b_out_data;
   logic [3:0]  b_fwd_src = '0;
   logic        b_fwd_hit;
   logic [15:0] b_fwd_data;
   logic [1:0]  b_occ;

   // Flush instance: LANES=2, DEPTH=3
   logic        c_stall = 1'b0, c_flush = 1'b0;
   logic [1:0]  c_in_wr_en = '0;
   logic [7:0]  c_in_dst = '0;
   logic [31:0] c_in_data = '0;
   logic [1:0]  c_out_wr_en;
   logic [7:0]  c_out_dst;
   logic [31:0] c_out_data;
   logic [3:0]  c_fwd_src = '0;
   logic        c_fwd_hit;
   logic [15:0] c_fwd_data;
   logic [2:0]  c_occ;

   // Occupancy instance: LANES=4, DEPTH=4
   logic        d_stall = 1'b0, d_flush = 1'b0;
   logic [3:0]  d_in_wr_en = '0;
   logic [15:0] d_in_dst = '0;
   logic [63:0] d_in_data = '0;
   logic [3:0]  d_out_wr_en;
   logic [15:0] d_out_dst;
   logic [63:0] d_out_data;
   logic [3:0]  d_fwd_src = '0;
   logic        d_fwd_hit;
   logic [15:0] d_fwd_data;
   logic [4:0]  d_occ;

   pipe_reg_ex_wb_multi #(.LANES(2), .DATA_W(16), .ADRS_W(4), .DEPTH(2)) dut_a (
      .clock(clock), .reset_n(reset_n), .stall(a_stall), .flush(a_flush),
      .in_wr_en(a_in_wr_en), .in_dst(a_in_dst), .in_data(a_in_data),
      .out_wr_en(a_out_wr_en), .out_dst(a_out_dst), .out_data(a_out_data),
      .fwd_src(a_fwd_src), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data), .occupancy(a_occ)
   );

   pipe_reg_ex_wb_multi #(.LANES(2), .DATA_W(16), .ADRS_W(4), .DEPTH(1)) dut_b (
      .clock(clock), .reset_n(reset_n), .stall(b_stall), .flush(b_flush),
      .in_wr_en(b_in_wr_en), .in_dst(b_in_dst), .in_data(b_in_data),
      .out_wr_en(b_out_wr_en), .out_dst(b_out_dst), .out_data(b_out_data),
      .fwd_src(b_fwd_src), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data), .occupancy(b_occ)
   );

   pipe_reg_ex_wb_multi #(.LANES(2), .DATA_W(16), .ADRS_W(4), .DEPTH(3)) dut_c (
      .clock(clock), .reset_n(reset_n), .stall(c_stall), .flush(c_flush),
      .in_wr_en(c_in_wr_en), .in_dst(c_in_dst), .in_data(c_in_data),
      .out_wr_en(c_out_wr_en), .out_dst(c_out_dst), .out_data(c_out_data),
      .fwd_src(c_fwd_src), .fwd_hit(c_fwd_hit), .fwd_data(c_fwd_data), .occupancy(c_occ)
   );

   pipe_reg_ex_wb_multi #(.LANES(4), .DATA_W(16), .ADRS_W(4), .DEPTH(4)) dut_d (
      .clock(clock), .reset_n(reset_n), .stall(d_stall), .flush(d_flush),
      .in_wr_en(d_in_wr_en), .in_dst(d_in_dst), .in_data(d_in_data),
      .out_wr_en(d_out_wr_en), .out_dst(d_out_dst), .out_data(d_out_data),
      .fwd_src(d_fwd_src), .fwd_hit(d_fwd_hit), .fwd_data(d_fwd_data), .occupancy(d_occ)
   );

   always #5 clock = ~clock;

   // Cycle counter used to timestamp expected arrival on the main instance.
   always @(posedge clock) cyc <= cyc + 1;

   // Direct comparison helper.
   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Drive one EX vector into the main instance and queue its hand-computed WB image.
   task automatic apply_stimulus(input logic [1:0] we, input logic [7:0] dst, input logic [31:0] data,
                                 input logic [7:0] exp_dst, input logic [31:0] exp_data);
      exp_t e;
      @(posedge clock);
      #1;
      a_in_wr_en = we;
      a_in_dst   = dst;
      a_in_data  = data;
      if (we != 2'b00) begin
         e.wr_en = we;
         e.dst   = exp_dst;
         e.data  = exp_data;
         e.cyc   = cyc + 2;
         sb_q.push_back(e);
      end
   endtask

   // Monitor: every valid WB presentation of the main instance is matched against the scoreboard.
   always @(negedge clock) begin
      if (reset_n && a_out_wr_en != 2'b00) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL wb_unexpected: actual we=%b dst=%h data=%h at cycle %0d, required no write",
                     a_out_wr_en, a_out_dst, a_out_data, cyc);
         end else begin
            sb_exp = sb_q.pop_front();
            if ({a_out_wr_en, a_out_dst, a_out_data} !== {sb_exp.wr_en, sb_exp.dst, sb_exp.data} ||
                cyc != sb_exp.cyc) begin
               n_fail++;
               $display("[TB] FAIL wb_output: actual we=%b dst=%h data=%h cycle=%0d, required we=%b dst=%h data=%h cycle=%0d",
                        a_out_wr_en, a_out_dst, a_out_data, cyc,
                        sb_exp.wr_en, sb_exp.dst, sb_exp.data, sb_exp.cyc);
            end
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_output("reset_a_out", {a_out_wr_en, a_out_dst, a_out_data, a_occ}, 64'h0);
      check_output("reset_occ_bcd", {b_occ, c_occ, d_occ}, 64'h0);
      reset_n = 1'b1;

      // Asynchronous reset mid-stream
      apply_stimulus(2'b11, 8'h43, 32'h2222_1111, 8'h43, 32'h2222_1111);
      apply_stimulus(2'b01, 8'h06, 32'h0000_6666, 8'h06, 32'h0000_6666);
      @(posedge clock);
      #1;
      check_output("prereset_out_we", a_out_wr_en, 2'b11);
      check_output("prereset_occ", a_occ, 3'd3);
      #1 reset_n = 1'b0;
      #1;
      check_output("async_reset_out", {a_out_wr_en, a_out_dst, a_out_data}, 64'h0);
      check_output("async_reset_occ", a_occ, 3'd0);
      sb_q.delete();
      a_in_wr_en = '0;
      a_in_dst   = '0;
      a_in_data  = '0;
      @(negedge clock);
      reset_n = 1'b1;

      // Latency: exactly two edges, present for one cycle
      apply_stimulus(2'b01, 8'h03, 32'h0000_ABCD, 8'h03, 32'h0000_ABCD);
      repeat (3) apply_stimulus(2'b00, 8'h00, 32'h0, 8'h00, 32'h0);

      // Forwarding priority: youngest stage, then highest lane
      apply_stimulus(2'b11, 8'h76, 32'h0001_0066, 8'h76, 32'h0001_0066);
      apply_stimulus(2'b11, 8'h77, 32'h0003_0002, 8'h77, 32'h0003_0002);
      apply_stimulus(2'b00, 8'h00, 32'h0, 8'h00, 32'h0);
      a_fwd_src = 4'd7;
      #1 check_output("fwd_youngest_high_lane", {a_fwd_hit, a_fwd_data}, {1'b1, 16'h0003});
      a_fwd_src = 4'd6;
      #1 check_output("fwd_older_stage", {a_fwd_hit, a_fwd_data}, {1'b1, 16'h0066});
      a_fwd_src = 4'd8;
      #1 check_output("fwd_miss", {a_fwd_hit, a_fwd_data}, {1'b0, 16'h0000});
      check_output("fwd_occ", a_occ, 3'd4);

      // Bubble canonicalisation on lane 0
      apply_stimulus(2'b10, 8'h29, 32'h5555_FFFF, 8'h20, 32'h5555_0000);
      apply_stimulus(2'b00, 8'h00, 32'h0, 8'h00, 32'h0);
      a_fwd_src = 4'd9;
      #1 check_output("bubble_fwd_miss", {a_fwd_hit, a_fwd_data}, {1'b0, 16'h0000});
      a_fwd_src = 4'd2;
      #1 check_output("bubble_fwd_lane1", {a_fwd_hit, a_fwd_data}, {1'b1, 16'h5555});
      repeat (3) apply_stimulus(2'b00, 8'h00, 32'h0, 8'h00, 32'h0);

      // Stall on depth 1
      @(posedge clock);
      #1;
      b_in_wr_en = 2'b10;
      b_in_dst   = 8'h50;
      b_in_data  = 32'h1234_0000;
      @(posedge clock);
      #1;
      b_stall    = 1'b1;
      b_in_wr_en = 2'b11;
      b_in_dst   = 8'hAA;
      b_in_data  = 32'h9999_8888;
      check_output("stall_capture", {b_out_wr_en, b_out_dst, b_out_data}, {2'b10, 8'h50, 32'h1234_0000});
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check_output("stall_hold", {b_out_wr_en, b_out_dst, b_out_data}, {2'b10, 8'h50, 32'h1234_0000});
         check_output("stall_occ", b_occ, 2'd1);
         b_in_data = b_in_data + 32'h0101_0101;
      end
      b_in_wr_en = '0;
      b_in_dst   = '0;
      b_in_data  = '0;
      b_stall    = 1'b0;
      @(posedge clock);
      #1;
      check_output("stall_release_occ", b_occ, 2'd0);

      // Flush beats stall on depth 3
      c_in_wr_en = 2'b11;
      c_in_dst   = 8'h21;
      c_in_data  = 32'hC001_C002;
      repeat (3) @(posedge clock);
      #1;
      check_output("flush_prefill_occ", c_occ, 3'd6);
      check_output("flush_prefill_out", {c_out_wr_en, c_out_dst, c_out_data}, {2'b11, 8'h21, 32'hC001_C002});
      c_flush = 1'b1;
      c_stall = 1'b1;
      @(posedge clock);
      #1;
      check_output("flush_over_stall_out", {c_out_wr_en, c_out_dst, c_out_data}, 64'h0);
      check_output("flush_over_stall_occ", c_occ, 3'd0);
      c_flush    = 1'b0;
      c_stall    = 1'b0;
      c_in_wr_en = '0;
      c_in_dst   = '0;
      c_in_data  = '0;

      // Full occupancy on 4 lanes x 4 stages
      d_in_wr_en = 4'hF;
      d_in_dst   = 16'h4321;
      d_in_data  = 64'h4444_3333_2222_1111;
      repeat (2) @(posedge clock);
      #1;
      check_output("occ_half", d_occ, 5'd8);
      repeat (2) @(posedge clock);
      #1;
      check_output("occ_full", d_occ, 5'd16);
      d_flush = 1'b1;
      @(posedge clock);
      #1;
      check_output("occ_after_flush", d_occ, 5'd0);
      d_flush    = 1'b0;
      d_in_wr_en = '0;

      // Every queued write must have been observed
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
      check_output("scoreboard_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
